// File: rtl/touch_mode_ctrl.sv
// Touch-key mode controller: synchronises and debounces the touch key, classifies
// each press as short or long, steps a 4-state display mode and drives the LED bank.
module touch_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned BLINK_CYC    = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       touch_key,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       short_press,
  output logic       long_press
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned LONG_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam int unsigned TICK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_RUN   = 2'd3
  } mode_t;

  logic              key_m;
  logic              key_s;
  logic              key_db;
  logic              key_db_q;
  logic [DB_W-1:0]   db_cnt;
  logic [LONG_W-1:0] hold_cnt;
  logic              long_done;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;
  mode_t             state;

  assign mode   = state;
  assign tick_c = (tick_cnt == TICK_LAST);

  // Two-flop synchroniser for the asynchronous touch key.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= touch_key;
      key_s <= key_m;
    end
  end

  // Accept a new key level only after DEBOUNCE_CYC consecutive mismatching cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_db <= 1'b0;
      db_cnt <= '0;
    end else if (key_s == key_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      key_db <= key_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Press classifier: long pulse after LONG_CYC held cycles, short pulse on an early release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_db_q    <= 1'b0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      key_db_q    <= key_db;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      if (!key_db) begin
        // Holding the counter cleared while released arms it for the next rising edge.
        hold_cnt  <= '0;
        long_done <= 1'b0;
        if (key_db_q && !long_done) begin
          short_press <= 1'b1;
        end
      end else if (!long_done) begin
        if (hold_cnt == LONG_LAST) begin
          long_press <= 1'b1;
          long_done  <= 1'b1;
          hold_cnt   <= '0;
        end else begin
          hold_cnt <= hold_cnt + LONG_W'(1);
        end
      end
    end
  end

  // Mode FSM, pattern tick and LED pattern; a mode change restarts tick and pattern.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= MODE_OFF;
      led      <= 4'b0000;
      tick_cnt <= '0;
    end else if (short_press || long_press) begin
      tick_cnt <= '0;
      if (long_press) begin
        state <= MODE_OFF;
        led   <= 4'b0000;
      end else begin
        case (state)
          MODE_OFF: begin
            state <= MODE_ON;
            led   <= 4'b1111;
          end
          MODE_ON: begin
            state <= MODE_BLINK;
            led   <= 4'b1111;
          end
          MODE_BLINK: begin
            state <= MODE_RUN;
            led   <= 4'b0001;
          end
          default: begin
            state <= MODE_OFF;
            led   <= 4'b0000;
          end
        endcase
      end
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
      if (tick_c) begin
        case (state)
          MODE_BLINK: led <= ~led;
          MODE_RUN:   led <= {led[2:0], led[3]};
          default:    led <= led;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_touch_mode_ctrl.sv
// Bench for touch_mode_ctrl: vector table, hand-written corner sequences and
// randomized key activity checked every cycle against a timeline-based model.
module tb_touch_mode_ctrl;

  localparam int DB = 4;
  localparam int LG = 20;
  localparam int BL = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       touch_key;
  logic [3:0] led;
  logic [1:0] mode;
  logic       short_press;
  logic       long_press;

  touch_mode_ctrl #(
    .DEBOUNCE_CYC(DB),
    .LONG_CYC    (LG),
    .BLINK_CYC   (BL)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .touch_key  (touch_key),
    .led        (led),
    .mode       (mode),
    .short_press(short_press),
    .long_press (long_press)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int sp_seen = 0;
  int lp_seen = 0;

  // Reference model: expressed as event times (key_db rise/fall, mode entry).
  int         n = 0;
  logic       m_km, m_ks, m_kdb;
  int         run;
  int         rise_t, fall_t;
  bit         fall_short;
  logic       m_sp, m_lp;
  logic [1:0] m_mode;
  int         entry_t;
  logic [3:0] m_led;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
    end
  endtask

  function automatic int pack(input logic sp, input logic lp, input logic [1:0] md,
                              input logic [3:0] ld);
    return int'({24'd0, sp, lp, md, ld});
  endfunction

  task automatic model_reset();
    m_km = 1'b0; m_ks = 1'b0; m_kdb = 1'b0; run = 0;
    rise_t = -1000; fall_t = -1000; fall_short = 1'b0;
    m_sp = 1'b0; m_lp = 1'b0; m_mode = 2'd0; entry_t = n; m_led = 4'h0;
  endtask

  task automatic model_edge(input logic k);
    logic ks_old, kdb_old, sp_old, lp_old;
    int   el;
    n++;
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    ks_old = m_ks; kdb_old = m_kdb; sp_old = m_sp; lp_old = m_lp;
    m_sp = (n == fall_t + 1) && fall_short;
    m_lp = kdb_old && (n - rise_t == LG);
    m_ks = m_km;
    m_km = k;
    if (ks_old != kdb_old) begin
      run++;
      if (run == DB) begin
        m_kdb = ks_old;
        run   = 0;
        if (ks_old) rise_t = n;
        else begin
          fall_t     = n;
          fall_short = (n - rise_t) < LG;
        end
      end
    end else begin
      run = 0;
    end
    if (sp_old) begin
      m_mode  = m_mode + 2'd1;
      entry_t = n;
    end else if (lp_old) begin
      m_mode  = 2'd0;
      entry_t = n;
    end
    el = n - entry_t;
    case (m_mode)
      2'd0:    m_led = 4'h0;
      2'd1:    m_led = 4'hF;
      2'd2:    m_led = (((el / BL) % 2) == 0) ? 4'hF : 4'h0;
      default: m_led = 4'(1 << ((el / BL) % 4));
    endcase
  endtask

  task automatic step(input logic k);
    touch_key = k;
    @(posedge sys_clk);
    model_edge(k);
    #1;
    check("model_step", pack(short_press, long_press, mode, led),
          pack(m_sp, m_lp, m_mode, m_led));
    if (short_press) sp_seen++;
    if (long_press)  lp_seen++;
  endtask

  task automatic do_short(input logic [1:0] exp_mode);
    logic [1:0] prev;
    prev = mode;
    repeat (10) step(1'b1);
    for (int i = 0; i < 20 && mode == prev; i++) step(1'b0);
    check("mode_advance", int'(mode), int'(exp_mode));
  endtask

  task automatic do_reset(input logic k);
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_led", int'(led), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_pulses", int'({short_press, long_press}), 0);
    repeat (3) step(k);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Hold the key for 40 cycles and report when the long pulse was seen.
  task automatic long_hold(output int lp_at, output int nlp);
    lp_at = -1;
    nlp   = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1);
      if (long_press) begin
        nlp++;
        if (lp_at < 0) lp_at = i;
      end
    end
  endtask

  typedef struct {
    logic        key;
    int          len;
    logic [1:0]  exp_mode;
    logic [3:0]  exp_led;
    int          exp_sp;
    int          exp_lp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    logic [3:0] run_pat[5];
    int got, lp_at, nlp;

    vecs[0] = '{1'b0, 100, 2'd0, 4'h0, 0, 0};
    vecs[1] = '{1'b1, 10,  2'd0, 4'h0, 0, 0};
    vecs[2] = '{1'b0, 10,  2'd1, 4'hF, 1, 0};
    vecs[3] = '{1'b1, 10,  2'd1, 4'hF, 0, 0};
    vecs[4] = '{1'b0, 10,  2'd2, 4'hF, 1, 0};
    vecs[5] = '{1'b1, 10,  2'd2, 4'h0, 0, 0};
    vecs[6] = '{1'b0, 20,  2'd3, 4'h2, 1, 0};
    vecs[7] = '{1'b1, 10,  2'd3, 4'h4, 0, 0};
    vecs[8] = '{1'b0, 10,  2'd0, 4'h0, 1, 0};
    run_pat[0] = 4'h1; run_pat[1] = 4'h2; run_pat[2] = 4'h4;
    run_pat[3] = 4'h8; run_pat[4] = 4'h1;

    sys_rst_n = 1'b0;
    touch_key = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_state", pack(short_press, long_press, mode, led), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Vector table: level, duration, expected mode/led and pulse counts.
    for (int v = 0; v < 9; v++) begin
      sp_seen = 0;
      lp_seen = 0;
      repeat (vecs[v].len) step(vecs[v].key);
      check($sformatf("vec%0d_mode", v), int'(mode), int'(vecs[v].exp_mode));
      check($sformatf("vec%0d_led", v), int'(led), int'(vecs[v].exp_led));
      check($sformatf("vec%0d_sp", v), sp_seen, vecs[v].exp_sp);
      check($sformatf("vec%0d_lp", v), lp_seen, vecs[v].exp_lp);
    end

    // Short-press latency from key release.
    repeat (10) step(1'b1);
    got = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0);
      if (short_press && got < 0) got = i;
      if (i == 8) begin
        check("short_mode", int'(mode), 1);
        check("short_led", int'(led), 15);
      end
    end
    check("short_latency", got, 7);

    // BLINK pattern from entry.
    do_short(2'd2);
    check("blink_e0", int'(led), 15);
    for (int e = 1; e <= 16; e++) begin
      step(1'b0);
      if (e == 7)  check("blink_e7", int'(led), 15);
      if (e == 8)  check("blink_e8", int'(led), 0);
      if (e == 15) check("blink_e15", int'(led), 0);
      if (e == 16) check("blink_e16", int'(led), 15);
    end

    // RUN pattern from entry.
    do_short(2'd3);
    check("run_e0", int'(led), int'(run_pat[0]));
    for (int e = 1; e <= 32; e++) begin
      step(1'b0);
      if (e % 8 == 0) check($sformatf("run_e%0d", e), int'(led), int'(run_pat[e / 8]));
    end

    // Long press in RUN, then a release that must not produce a short pulse.
    long_hold(lp_at, nlp);
    check("long_at", lp_at, 6 + LG);
    check("long_count", nlp, 1);
    check("long_mode", int'(mode), 0);
    check("long_led", int'(led), 0);
    sp_seen = 0;
    repeat (20) step(1'b0);
    check("long_release_sp", sp_seen, 0);

    // Glitch bursts shorter than the debounce window.
    do_short(2'd1);
    sp_seen = 0;
    lp_seen = 0;
    repeat (12) begin
      repeat (3) step(1'b1);
      repeat (2) step(1'b0);
    end
    repeat (10) step(1'b0);
    check("glitch_sp", sp_seen, 0);
    check("glitch_lp", lp_seen, 0);
    check("glitch_mode", int'(mode), 1);

    // Reset mid-BLINK with the key held; held key becomes a fresh long press.
    do_short(2'd2);
    repeat (5) step(1'b0);
    repeat (3) step(1'b1);
    do_reset(1'b1);
    long_hold(lp_at, nlp);
    check("rst_long_at", lp_at, 6 + LG);
    check("rst_long_count", nlp, 1);
    sp_seen = 0;
    repeat (20) step(1'b0);
    check("rst_release_sp", sp_seen, 0);
    check("rst_final_mode", int'(mode), 0);

    // Randomized key activity with occasional resets.
    for (int s = 0; s < 200; s++) begin
      logic k;
      int   len;
      k   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 40));
      repeat (len) step(k);
      if ($urandom_range(0, 49) == 0) do_reset(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
